vproc_cmd_engine: RTL and testbench

// - Synthesisable, parametrised successor to the VProc bus master: same bus side (Addr/BE/WE/RD/DataOut/DataIn/acks/Burst*).
// - Commands arrive on a valid/ready stream instead of from software scheduling calls.
// - Adds generic data/address widths, burst write-data streaming, post-access tick delays, a read-response stream and interrupt-change reporting.
// - Sits between a command source (DPI shim, FIFO or on-chip sequencer) and any VProc-compatible bus slave.

---
 rtl/vproc_cmd_engine.sv | 201 ++++++++++++++++++++
 tb/tb_vproc_cmd_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_cmd_engine.sv
// Stream-driven VProc-compatible bus master: commands in, bus accesses out, read data and irq changes back.
// Optional per-beat ack watchdog is built when VPROC_ACK_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | CmdReady high, waiting for a command
// ACCESS | WE or RD asserted, waiting for the matching ack
// WWAIT  | burst write stalled until WrValid supplies the next beat
// DELAY  | post-command tick delay, CmdReady low
module vproc_cmd_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INT_WIDTH   = 3,
    parameter int ADDR_INCR   = 1,
    parameter int TICK_WIDTH  = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                    Clk,
    input  logic                    nReset,
    input  logic                    CmdValid,
    output logic                    CmdReady,
    input  logic [ADDR_WIDTH-1:0]   CmdAddr,
    input  logic [DATA_WIDTH-1:0]   CmdData,
    input  logic [DATA_WIDTH/8-1:0] CmdBE,
    input  logic                    CmdWE,
    input  logic                    CmdRD,
    input  logic [11:0]             CmdBurst,
    input  logic [TICK_WIDTH-1:0]   CmdTicks,
    input  logic                    WrValid,
    output logic                    WrReady,
    input  logic [DATA_WIDTH-1:0]   WrData,
    output logic                    RspValid,
    output logic [DATA_WIDTH-1:0]   RspData,
    output logic                    RspLast,
    output logic                    RspErr,
    output logic [ADDR_WIDTH-1:0]   Addr,
    output logic [DATA_WIDTH/8-1:0] BE,
    output logic                    WE,
    output logic                    RD,
    output logic [DATA_WIDTH-1:0]   DataOut,
    input  logic [DATA_WIDTH-1:0]   DataIn,
    input  logic                    WRAck,
    input  logic                    RDAck,
    output logic [11:0]             Burst,
    output logic                    BurstFirst,
    output logic                    BurstLast,
    input  logic [INT_WIDTH-1:0]    Interrupt,
    output logic                    IrqValid,
    output logic [INT_WIDTH-1:0]    IrqVector
);

    typedef enum logic [1:0] {IDLE, ACCESS, WWAIT, DELAY} state_t;

    state_t                state, state_nxt;
    logic                  is_wr;
    logic [11:0]           beats_left;
    logic [11:0]           cmd_beats;
    logic [TICK_WIDTH-1:0] count;
    logic                  accept, ack_hit, more, wr_take, timeout;

    always_comb begin
        cmd_beats = (CmdBurst == 12'd0) ? 12'd1 : CmdBurst;
        accept    = CmdValid && (state == IDLE);
        ack_hit   = (state == ACCESS) && (is_wr ? (WE && WRAck) : (RD && RDAck));
        more      = (beats_left > 12'd1);
        wr_take   = WrValid && ((ack_hit && is_wr && more) || (state == WWAIT));
        state_nxt = state;
        case (state)
            IDLE:   if (accept) state_nxt = (CmdWE || CmdRD) ? ACCESS : DELAY;
            ACCESS: begin
                if (ack_hit) begin
                    if (more)
                        state_nxt = (is_wr && !WrValid) ? WWAIT : ACCESS;
                    else
                        state_nxt = (count != '0) ? DELAY : IDLE;
                end else if (timeout) begin
                    state_nxt = (count != '0) ? DELAY : IDLE;
                end
            end
            WWAIT:  if (WrValid) state_nxt = ACCESS;
            DELAY:  if (count <= TICK_WIDTH'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign CmdReady = (state == IDLE);
    assign WrReady  = wr_take;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            is_wr      <= 1'b0;
            beats_left <= '0;
            count      <= '0;
            Addr       <= '0;
            BE         <= '0;
            DataOut    <= '0;
            Burst      <= '0;
            WE         <= 1'b0;
            RD         <= 1'b0;
            BurstFirst <= 1'b0;
            BurstLast  <= 1'b0;
            RspValid   <= 1'b0;
            RspData    <= '0;
            RspLast    <= 1'b0;
            IrqValid   <= 1'b0;
            IrqVector  <= '0;
        end else begin
            RspValid <= 1'b0;
            RspLast  <= 1'b0;
            IrqValid <= 1'b0;
            if (Interrupt != IrqVector) begin
                IrqVector <= Interrupt;
                IrqValid  <= 1'b1;
            end
            case (state)
                IDLE: if (accept) begin
                    count <= CmdTicks;
                    is_wr <= CmdWE;
                    if (CmdWE || CmdRD) begin
                        Addr       <= CmdAddr;
                        BE         <= CmdBE;
                        DataOut    <= CmdData;
                        Burst      <= cmd_beats;
                        beats_left <= cmd_beats;
                        WE         <= CmdWE;
                        RD         <= !CmdWE;
                        BurstFirst <= (cmd_beats > 12'd1);
                        BurstLast  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (ack_hit) begin
                        if (!is_wr) begin
                            RspValid <= 1'b1;
                            RspData  <= DataIn;
                            RspLast  <= !more;
                        end
                        if (more) begin
                            beats_left <= beats_left - 12'd1;
                            Addr       <= Addr + ADDR_WIDTH'(ADDR_INCR);
                            BurstFirst <= 1'b0;
                            BurstLast  <= (beats_left == 12'd2);
                            if (is_wr) begin
                                if (WrValid) DataOut <= WrData;
                                else         WE      <= 1'b0;
                            end
                        end else begin
                            WE         <= 1'b0;
                            RD         <= 1'b0;
                            BurstFirst <= 1'b0;
                            BurstLast  <= 1'b0;
                        end
                    end else if (timeout) begin
                        // abandoned reads still close the response stream
                        WE         <= 1'b0;
                        RD         <= 1'b0;
                        BurstFirst <= 1'b0;
                        BurstLast  <= 1'b0;
                        if (!is_wr) begin
                            RspValid <= 1'b1;
                            RspLast  <= 1'b1;
                        end
                    end
                end
                WWAIT: if (WrValid) begin
                    DataOut <= WrData;
                    WE      <= 1'b1;
                end
                DELAY: if (count > TICK_WIDTH'(1)) count <= count - TICK_WIDTH'(1);
                default: ;
            endcase
        end
    end

`ifdef VPROC_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout = (state == ACCESS) && !ack_hit && (to_cnt == TO_W'(1));

    // held at full scale outside ACCESS so every (re)assertion gets a fresh window
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            to_cnt <= '0;
            RspErr <= 1'b0;
        end else begin
            RspErr <= timeout && !is_wr;
            if ((state != ACCESS) || ack_hit) to_cnt <= TO_W'(ACK_TIMEOUT);
            else if (to_cnt != '0)             to_cnt <= to_cnt - TO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
    assign RspErr  = 1'b0;
`endif

endmodule

// File: tb/tb_vproc_cmd_engine.sv
// Scoreboard bench for vproc_cmd_engine: directed commands push expected bus beats,
// read responses and irq events; a monitor pops and compares whenever the DUT presents them.
module tb_vproc_cmd_engine;

    logic        Clk = 1'b0;
    logic        nReset = 1'b1;
    logic        CmdValid = 1'b0, CmdReady;
    logic [31:0] CmdAddr = '0, CmdData = '0;
    logic [3:0]  CmdBE = '0;
    logic        CmdWE = 1'b0, CmdRD = 1'b0;
    logic [11:0] CmdBurst = '0;
    logic [15:0] CmdTicks = '0;
    logic        WrValid = 1'b0, WrReady;
    logic [31:0] WrData = '0;
    logic        RspValid, RspLast, RspErr;
    logic [31:0] RspData;
    logic [31:0] Addr, DataOut;
    logic [31:0] DataIn = '0;
    logic [3:0]  BE;
    logic        WE, RD;
    logic        WRAck = 1'b0, RDAck = 1'b0;
    logic [11:0] Burst;
    logic        BurstFirst, BurstLast;
    logic [2:0]  Interrupt = '0;
    logic        IrqValid;
    logic [2:0]  IrqVector;

    vproc_cmd_engine #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .INT_WIDTH(3), .ADDR_INCR(1),
        .TICK_WIDTH(16), .ACK_TIMEOUT(8)
    ) dut (
        .Clk(Clk), .nReset(nReset),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdAddr(CmdAddr), .CmdData(CmdData),
        .CmdBE(CmdBE), .CmdWE(CmdWE), .CmdRD(CmdRD), .CmdBurst(CmdBurst), .CmdTicks(CmdTicks),
        .WrValid(WrValid), .WrReady(WrReady), .WrData(WrData),
        .RspValid(RspValid), .RspData(RspData), .RspLast(RspLast), .RspErr(RspErr),
        .Addr(Addr), .BE(BE), .WE(WE), .RD(RD), .DataOut(DataOut), .DataIn(DataIn),
        .WRAck(WRAck), .RDAck(RDAck), .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast),
        .Interrupt(Interrupt), .IrqValid(IrqValid), .IrqVector(IrqVector)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [11:0] burst;
        logic        first;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    beat_t      bus_q[$];
    rsp_t       rsp_q[$];
    logic [2:0] irq_q[$];
    beat_t      b;
    rsp_t       r;
    logic [2:0] iv;

    int checks = 0, errors = 0;
    int wr_pulses = 0, irq_pulses = 0, bus_seen = 0;
    int ack_lat = 0, wcnt = 0;
    logic slave_on = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // bus slave: ack after ack_lat idle cycles, read data derived from the address
    always @(negedge Clk) begin
        if (slave_on && (WRAck || RDAck)) begin
            WRAck = 1'b0;
            RDAck = 1'b0;
            wcnt  = 0;
        end else if (slave_on && nReset && (WE || RD)) begin
            if (wcnt >= ack_lat) begin
                WRAck  = WE;
                RDAck  = RD;
                DataIn = {16'hC0DE, Addr[15:0]};
            end else begin
                wcnt++;
            end
        end
    end

    // monitor: sampled mid low phase, well away from the rising edge
    always @(negedge Clk) begin
        #2;
        if (nReset) begin
            if (WE || RD) bus_seen++;
            if (WrReady) wr_pulses++;
            if ((WE && WRAck) || (RD && RDAck)) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: beat at addr 0x%0h, expected none", Addr);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_dir", 64'({WE, RD}), 64'({b.we, !b.we}));
                    chk("bus_addr", 64'(Addr), 64'(b.addr));
                    chk("bus_be", 64'(BE), 64'(b.be));
                    if (b.we) chk("bus_data", 64'(DataOut), 64'(b.data));
                    chk("bus_burst", 64'(Burst), 64'(b.burst));
                    chk("bus_first_last", 64'({BurstFirst, BurstLast}), 64'({b.first, b.last}));
                end
            end
            if (RspValid) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: data 0x%0h, expected none", RspData);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_last_err", 64'({RspLast, RspErr}), 64'({r.last, r.err}));
                    if (!r.err) chk("rsp_data", 64'(RspData), 64'(r.data));
                end
            end
            if (IrqValid) begin
                irq_pulses++;
                if (irq_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL irq_unexpected: vector %0d, expected none", IrqVector);
                end else begin
                    iv = irq_q.pop_front();
                    chk("irq_vector", 64'(IrqVector), 64'(iv));
                end
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic we, input logic rd, input logic [11:0] burst,
                            input logic [15:0] ticks);
        int n = 0;
        while (!CmdReady && n < 200) begin @(posedge Clk); #1; n++; end
        chk("cmd_ready_wait", 64'(CmdReady), 64'(1));
        CmdAddr = a; CmdData = d; CmdBE = be; CmdWE = we; CmdRD = rd;
        CmdBurst = burst; CmdTicks = ticks; CmdValid = 1'b1;
        @(posedge Clk); #1;
        CmdValid = 1'b0; CmdWE = 1'b0; CmdRD = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!CmdReady && n < 200) begin @(posedge Clk); #1; n++; end
        chk("ready_timeout", 64'(CmdReady), 64'(1));
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_addr_data"}, 64'({Addr, DataOut}), 64'(0));
        chk({tag, "_ctrl"}, 64'({WE, RD, BE, Burst, BurstFirst, BurstLast, RspValid, RspLast,
                                 RspErr, IrqValid, IrqVector, WrReady}), 64'(0));
        chk({tag, "_rsp_data"}, 64'(RspData), 64'(0));
        chk({tag, "_cmd_ready"}, 64'(CmdReady), 64'(1));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        #1 nReset = 1'b0;
        #3 reset_check("reset");
        @(posedge Clk); #1 nReset = 1'b1;
        @(posedge Clk); #1;

        // single write, ack 3 cycles after WE rises
        ack_lat = 2;
        bus_q.push_back('{1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 12'd1, 1'b0, 1'b0});
        send_cmd(32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 12'd1, 16'd0);
        n = 0;
        while (WE && n < 100) begin @(posedge Clk); #1; n++; end
        chk("single_we_cycles", 64'(n), 64'(3));
        chk("single_ready_after_ack", 64'(CmdReady), 64'(1));

        // 4-beat read
        ack_lat = 1;
        for (int i = 0; i < 4; i++) begin
            bus_q.push_back('{1'b0, 32'h10 + 32'(i), 4'hF, 32'h0, 12'd4, (i == 0), (i == 3)});
            rsp_q.push_back('{32'hC0DE0010 + 32'(i), (i == 3), 1'b0});
        end
        send_cmd(32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 12'd4, 16'd0);
        wait_ready(n);

        // 3-beat write with a two-cycle WrValid gap before beat 2
        ack_lat = 0;
        base = wr_pulses;
        bus_q.push_back('{1'b1, 32'h200, 4'h3, 32'h11111111, 12'd3, 1'b1, 1'b0});
        bus_q.push_back('{1'b1, 32'h201, 4'h3, 32'h22222222, 12'd3, 1'b0, 1'b0});
        bus_q.push_back('{1'b1, 32'h202, 4'h3, 32'h33333333, 12'd3, 1'b0, 1'b1});
        WrData = 32'h22222222; WrValid = 1'b1;
        send_cmd(32'h200, 32'h11111111, 4'h3, 1'b1, 1'b0, 12'd3, 16'd0);
        n = 0;
        while (wr_pulses < base + 1 && n < 50) begin @(posedge Clk); #1; n++; end
        WrValid = 1'b0;
        n = 0;
        while (WE && n < 50) begin @(posedge Clk); #1; n++; end
        chk("wgap_we_dropped", 64'(WE), 64'(0));
        @(posedge Clk); #1;
        chk("wgap_we_held_low", 64'(WE), 64'(0));
        WrData = 32'h33333333; WrValid = 1'b1;
        @(posedge Clk); #1;
        chk("wgap_we_reasserted", 64'(WE), 64'(1));
        WrValid = 1'b0;
        wait_ready(n);
        chk("wgap_wrready_pulses", 64'(wr_pulses - base), 64'(2));

        // delay-only command
        base = bus_seen;
        send_cmd(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 12'd1, 16'd5);
        wait_ready(n);
        chk("delay_ready_low_cycles", 64'(n), 64'(5));
        chk("delay_no_bus", 64'(bus_seen - base), 64'(0));

        // burst 0 treated as 1, WE wins over RD, 3 tick delay after the ack
        bus_q.push_back('{1'b1, 32'h400, 4'h1, 32'hCAFEF00D, 12'd1, 1'b0, 1'b0});
        send_cmd(32'h400, 32'hCAFEF00D, 4'h1, 1'b1, 1'b1, 12'd0, 16'd3);
        wait_ready(n);
        chk("post_ticks_low_cycles", 64'(n), 64'(4));

        // 2-beat read wrapping the address space
        bus_q.push_back('{1'b0, 32'hFFFFFFFF, 4'hC, 32'h0, 12'd2, 1'b1, 1'b0});
        bus_q.push_back('{1'b0, 32'h00000000, 4'hC, 32'h0, 12'd2, 1'b0, 1'b1});
        rsp_q.push_back('{32'hC0DEFFFF, 1'b0, 1'b0});
        rsp_q.push_back('{32'hC0DE0000, 1'b1, 1'b0});
        send_cmd(32'hFFFFFFFF, 32'h0, 4'hC, 1'b0, 1'b1, 12'd2, 16'd0);
        wait_ready(n);

        // stray acks while idle are ignored
        slave_on = 1'b0;
        WRAck = 1'b1; RDAck = 1'b1;
        @(posedge Clk); #1;
        WRAck = 1'b0; RDAck = 1'b0; wcnt = 0;
        chk("stray_ack_ready", 64'(CmdReady), 64'(1));
        chk("stray_ack_bus", 64'({WE, RD}), 64'(0));
        slave_on = 1'b1;

        // interrupt 0 -> 3 -> 3 -> 1 -> 0
        base = irq_pulses;
        irq_q.push_back(3'd3); irq_q.push_back(3'd1); irq_q.push_back(3'd0);
        Interrupt = 3'd3; @(posedge Clk); #1;
        Interrupt = 3'd3; @(posedge Clk); #1;
        Interrupt = 3'd1; @(posedge Clk); #1;
        Interrupt = 3'd0; @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("irq_pulse_count", 64'(irq_pulses - base), 64'(3));

        // reset in the middle of an unacked burst write
        slave_on = 1'b0;
        send_cmd(32'h300, 32'h55AA55AA, 4'hF, 1'b1, 1'b0, 12'd4, 16'd0);
        @(posedge Clk); #1;
        nReset = 1'b0;
        #1 reset_check("midreset");
        @(posedge Clk); #1 nReset = 1'b1;
        wcnt = 0; slave_on = 1'b1; ack_lat = 0;
        bus_q.push_back('{1'b0, 32'h40, 4'hF, 32'h0, 12'd1, 1'b0, 1'b0});
        rsp_q.push_back('{32'hC0DE0040, 1'b1, 1'b0});
        send_cmd(32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 12'd1, 16'd0);
        wait_ready(n);

`ifdef VPROC_ACK_TIMEOUT_EN
        // read with no ack: RD drops after 8 cycles with an error response
        slave_on = 1'b0;
        rsp_q.push_back('{32'h0, 1'b1, 1'b1});
        send_cmd(32'h50, 32'h0, 4'hF, 1'b0, 1'b1, 12'd3, 16'd0);
        n = 0;
        while (RD && n < 100) begin @(posedge Clk); #1; n++; end
        chk("timeout_rd_cycles", 64'(n), 64'(8));
        chk("timeout_ready", 64'(CmdReady), 64'(1));
        @(posedge Clk); #1;
        slave_on = 1'b1; wcnt = 0;
`endif

        repeat (3) @(posedge Clk);
        #1;
        chk("bus_q_drained", 64'(bus_q.size()), 64'(0));
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        chk("irq_q_drained", 64'(irq_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
